// File: rtl/johnson_decoder_pkg.sv
// Shared types and helpers for the Johnson code decoder: FSM states,
// error counter width and the Johnson successor function.
package johnson_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam int MAX_N     = 8;

  // Shift-left Johnson successor of an n-bit code, zero-extended to MAX_N bits.
  function automatic logic [MAX_N-1:0] johnson_succ(input logic [MAX_N-1:0] c, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_N; i++) begin
      if (i < n) r[i] = c[i-1];
    end
    r[0] = ~c[n-1];
    return r;
  endfunction

endpackage

// File: rtl/johnson_decoder_lut.sv
// Combinational Johnson code decoder: maps a code word to its position
// in the sequence and flags words that are not part of the sequence.
module johnson_lut #(
  parameter int N = 4
) (
  input  logic [N-1:0]             code,
  output logic [$clog2(2*N)-1:0]   idx,
  output logic                     legal
);

  localparam int IW = $clog2(2*N);
  // When 2N is a power of two this truncates to zero, which still gives
  // the right result because the subtraction below wraps modulo 2^IW.
  localparam logic [IW-1:0] TWO_N = IW'(2*N);

  logic [IW-1:0] pop;
  logic          low_fill;
  logic [N-1:0]  pattern;

  // Decode by popcount, then rebuild the ideal word for that position;
  // the code is legal only if it matches the rebuilt word exactly.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + IW'(code[i]);
    low_fill = code[0] || (code == '0);
    pattern  = '0;
    for (int i = 0; i < N; i++) begin
      pattern[i] = low_fill ? (i < int'(pop)) : (i >= N - int'(pop));
    end
    idx   = low_fill ? pop : (TWO_N - pop);
    legal = (pattern == code);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter monitor: decodes sampled codes, checks that each legal
// sample follows its predecessor, and tracks lock and error statistics.
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N-1:0]           code,
  output logic [$clog2(2*N)-1:0] idx,
  output logic                   idx_valid,
  output logic                   illegal,
  output logic                   seq_err,
  output logic                   locked,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int IW = $clog2(2*N);

  state_t        state, next_state;
  logic [3:0]    step_cnt, next_step;
  logic [N-1:0]  prev_code;
  logic          have_prev;

  logic [IW-1:0] lut_idx;
  logic          lut_legal;
  logic          sample_illegal, sample_seq, sample_err, good_step;

  johnson_lut #(.N(N)) u_lut (
    .code  (code),
    .idx   (lut_idx),
    .legal (lut_legal)
  );

  // Classify the current sample against the stored previous legal code.
  always_comb begin
    sample_illegal = in_valid && !lut_legal;
    sample_seq     = 1'b0;
    good_step      = 1'b0;
    if (in_valid && lut_legal && have_prev) begin
      if (MAX_N'(code) == johnson_succ(MAX_N'(prev_code), N)) good_step = 1'b1;
      else                                                   sample_seq = 1'b1;
    end
    sample_err = sample_illegal || sample_seq;
  end

  // Lock FSM next-state logic; ERROR is a single-cycle pass back to HUNT.
  always_comb begin
    next_state = state;
    next_step  = step_cnt;
    case (state)
      HUNT: begin
        if (sample_err) begin
          next_step = '0;
        end else if (good_step) begin
          if (4'(step_cnt + 4'd1) == 4'(LOCK_CNT)) begin
            next_state = LOCKED;
            next_step  = '0;
          end else begin
            next_step = 4'(step_cnt + 4'd1);
          end
        end
      end
      LOCKED: begin
        if (sample_err) next_state = ERROR;
      end
      ERROR: begin
        next_state = HUNT;
        next_step  = '0;
      end
      default: begin
        next_state = HUNT;
        next_step  = '0;
      end
    endcase
  end

  // FSM state and step counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      step_cnt <= '0;
    end else begin
      state    <= next_state;
      step_cnt <= next_step;
    end
  end

  // Registered outputs, previous-code tracking and saturating error count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
      prev_code <= '0;
      have_prev <= 1'b0;
    end else begin
      idx_valid <= in_valid && lut_legal;
      illegal   <= sample_illegal;
      seq_err   <= sample_seq;
      locked    <= (next_state == LOCKED);
      if (in_valid && lut_legal) begin
        idx       <= lut_idx;
        prev_code <= code;
        have_prev <= 1'b1;
      end
      if (sample_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed self-checking bench for johnson_decoder with N=4, LOCK_CNT=3.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] code;
  logic [2:0] idx;
  logic       idx_valid, illegal, seq_err, locked;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int err_model;

  johnson_decoder #(.N(4), .LOCK_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .code      (code),
    .idx       (idx),
    .idx_valid (idx_valid),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drive one sample on the falling edge, then settle past the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    code     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int e_idx, input int e_v, input int e_ill,
                          input int e_seq, input int e_lock, input int e_err);
    checkOutput({tag, ".idx"},       int'(idx),       e_idx);
    checkOutput({tag, ".idx_valid"}, int'(idx_valid), e_v);
    checkOutput({tag, ".illegal"},   int'(illegal),   e_ill);
    checkOutput({tag, ".seq_err"},   int'(seq_err),   e_seq);
    checkOutput({tag, ".locked"},    int'(locked),    e_lock);
    checkOutput({tag, ".err_cnt"},   int'(err_cnt),   e_err);
  endtask

  // Directed sequence: lock-up, wrap, illegal, skip, repeat, saturation, reset.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; code = 4'b0000;
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkAll("reset", 0, 0, 0, 0, 0, 0);

    applyStimulus(1'b1, 1'b1, 4'b0000); checkAll("s0000", 0, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4'b0001); checkAll("s0001", 1, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4'b0011); checkAll("s0011", 2, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4'b0111); checkAll("s0111_lock", 3, 1, 0, 0, 1, 0);

    applyStimulus(1'b1, 1'b0, 4'b0101); checkAll("idle_hold", 3, 0, 0, 0, 1, 0);

    applyStimulus(1'b1, 1'b1, 4'b1111); checkAll("s1111", 4, 1, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 4'b1110); checkAll("s1110", 5, 1, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 4'b1100); checkAll("s1100", 6, 1, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 4'b1000); checkAll("s1000", 7, 1, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 4'b0000); checkAll("wrap0000", 0, 1, 0, 0, 1, 0);

    applyStimulus(1'b1, 1'b1, 4'b0101); checkAll("illegal0101", 0, 0, 1, 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 4'b0001); checkAll("error_cycle", 1, 1, 0, 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 4'b0011); checkAll("hunt0011", 2, 1, 0, 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 4'b1111); checkAll("skip1111", 4, 1, 0, 1, 0, 2);

    applyStimulus(1'b1, 1'b1, 4'b1110); checkAll("relock1", 5, 1, 0, 0, 0, 2);
    applyStimulus(1'b1, 1'b1, 4'b1100); checkAll("relock2", 6, 1, 0, 0, 0, 2);
    applyStimulus(1'b1, 1'b1, 4'b1000); checkAll("relock3", 7, 1, 0, 0, 1, 2);

    applyStimulus(1'b1, 1'b1, 4'b1000); checkAll("repeat1000", 7, 1, 0, 1, 0, 3);
    applyStimulus(1'b1, 1'b0, 4'b0000); checkAll("error_to_hunt", 7, 0, 0, 0, 0, 3);

    err_model = 3;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? 4'b0101 : 4'b1010);
      err_model = (err_model == 255) ? 255 : err_model + 1;
      checkOutput("sat.illegal", int'(illegal), 1);
      checkOutput("sat.err_cnt", int'(err_cnt), err_model);
    end
    checkAll("saturated", 7, 0, 1, 0, 0, 255);

    applyStimulus(1'b0, 1'b1, 4'b0001); checkAll("mid_reset", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4'b0011); checkAll("first_after_reset", 2, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
